// File: rtl/pll_speed_ctl_pkg.sv
// Shared constants for the PLL CPU-clock reconfiguration sequencer:
// reconfig register map, C-counter data layout, speed presets and FSM states.
package pll_speed_ctl_pkg;

    localparam logic [5:0] ADDR_MODE   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_START  = 6'h02;
    localparam logic [5:0] ADDR_C      = 6'h05;

    localparam int C_SEL_LSB = 18;
    localparam int C_SEL_W   = 5;
    localparam int C_ODD_BIT = 17;
    localparam int C_BYP_BIT = 16;
    localparam int C_HI_LSB  = 8;
    localparam int C_LO_LSB  = 0;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       odd;
    } preset_t;

    // Divide settings from a 1600 MHz VCO, slowest to fastest
    localparam preset_t PRESETS [4] = '{
        '{hi: 8'd224, lo: 8'd223, odd: 1'b1},
        '{hi: 8'd112, lo: 8'd112, odd: 1'b0},
        '{hi: 8'd56,  lo: 8'd56,  odd: 1'b0},
        '{hi: 8'd28,  lo: 8'd28,  odd: 1'b0}
    };

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_C,
        S_WR_START,
        S_RD_STAT,
        S_RD_GAP,
        S_WAIT_LOCK,
        S_SETTLE,
        S_FAIL
    } state_t;

    function automatic logic [31:0] c_data(
        input logic [1:0]         sel,
        input logic [C_SEL_W-1:0] idx
    );
        logic [31:0] d;
        d                     = '0;
        d[C_SEL_LSB+:C_SEL_W] = idx;
        d[C_ODD_BIT]          = PRESETS[sel].odd;
        d[C_BYP_BIT]          = 1'b0;
        d[C_HI_LSB+:8]        = PRESETS[sel].hi;
        d[C_LO_LSB+:8]        = PRESETS[sel].lo;
        return d;
    endfunction

endpackage

// File: rtl/pll_speed_ctl.sv
// Reprograms the PLL CPU-clock C counter on a speed change, holding the
// CPU domain frozen until the PLL has re-locked and settled.
module pll_speed_ctl
    import pll_speed_ctl_pkg::*;
#(
    parameter int C_INDEX     = 4,
    parameter int RESET_SEL   = 0,
    parameter int SETTLE_CYC  = 1024,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  speed_sel,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    output logic        clk_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  cur_sel
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

    state_t        state, state_n;
    logic [1:0]    target, target_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [SW-1:0] set_cnt, set_n;
    logic [5:0]    addr_n;
    logic          wr_n, rd_n;
    logic [31:0]   wdata_n;
    logic [1:0]    cur_n;
    logic          done_n, err_n;
    logic          timed;
    logic          unused_rd;

    assign unused_rd = ^mgmt_readdata[31:1];
    assign clk_hold  = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            target         <= 2'(RESET_SEL);
            tmo            <= '0;
            set_cnt        <= '0;
            mgmt_address   <= '0;
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            mgmt_writedata <= '0;
            cur_sel        <= 2'(RESET_SEL);
            done           <= 1'b0;
            err            <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            target         <= target_n;
            tmo            <= tmo_n;
            set_cnt        <= set_n;
            mgmt_address   <= addr_n;
            mgmt_write     <= wr_n;
            mgmt_read      <= rd_n;
            mgmt_writedata <= wdata_n;
            cur_sel        <= cur_n;
            done           <= done_n;
            err            <= err_n;
            busy           <= (state_n != S_IDLE);
        end
    end

    // Strobes are issued on entry to a bus state so each transfer starts
    // in the first cycle of its state and back-to-back writes chain.
    always_comb begin
        state_n  = state;
        target_n = target;
        tmo_n    = tmo;
        set_n    = set_cnt;
        addr_n   = mgmt_address;
        wr_n     = mgmt_write;
        rd_n     = mgmt_read;
        wdata_n  = mgmt_writedata;
        cur_n    = cur_sel;
        done_n   = 1'b0;
        err_n    = err;
        timed    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (speed_sel != cur_sel) begin
                    target_n = speed_sel;
                    state_n  = S_WR_MODE;
                    wr_n     = 1'b1;
                    addr_n   = ADDR_MODE;
                    wdata_n  = 32'd1;
                end
            end
            S_WR_MODE: begin
                if (!mgmt_waitrequest) begin
                    state_n = S_WR_C;
                    addr_n  = ADDR_C;
                    wdata_n = c_data(target, C_SEL_W'(C_INDEX));
                end
            end
            S_WR_C: begin
                if (!mgmt_waitrequest) begin
                    state_n = S_WR_START;
                    addr_n  = ADDR_START;
                    wdata_n = '0;
                end
            end
            S_WR_START: begin
                if (!mgmt_waitrequest) begin
                    state_n = S_RD_STAT;
                    wr_n    = 1'b0;
                    rd_n    = 1'b1;
                    addr_n  = ADDR_STATUS;
                    wdata_n = '0;
                    tmo_n   = '0;
                end
            end
            S_RD_STAT: begin
                timed = 1'b1;
                if (!mgmt_waitrequest) begin
                    rd_n    = 1'b0;
                    state_n = mgmt_readdata[0] ? S_WAIT_LOCK : S_RD_GAP;
                end
            end
            S_RD_GAP: begin
                timed   = 1'b1;
                state_n = S_RD_STAT;
                rd_n    = 1'b1;
            end
            S_WAIT_LOCK: begin
                timed = 1'b1;
                if (pll_locked) begin
                    // The first locked cycle already counts toward settling
                    set_n   = SW'(1);
                    state_n = S_SETTLE;
                    if (SETTLE_CYC <= 1) begin
                        state_n = S_IDLE;
                        cur_n   = target;
                        done_n  = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                timed = 1'b1;
                if (!pll_locked) begin
                    set_n = '0;
                end else if (set_cnt == SET_LAST) begin
                    state_n = S_IDLE;
                    cur_n   = target;
                    done_n  = 1'b1;
                end else begin
                    set_n = set_cnt + SW'(1);
                end
            end
            S_FAIL: begin
                err_n   = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Timeout spans status polling, lock wait and settling, and wins
        if (timed) begin
            if (tmo == TMO_LAST) begin
                state_n = S_FAIL;
                rd_n    = 1'b0;
                cur_n   = cur_sel;
                done_n  = 1'b0;
            end else begin
                tmo_n = tmo + TW'(1);
            end
        end
    end

endmodule
